// File: rtl/ecc_secded_engine.sv
// rtl/ecc_secded_engine.sv - APB-controlled SECDED encode/decode engine for 8/16/32-bit codewords
module ecc_secded_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);
    // Internal datapath is always sized for the largest codeword; narrower widths use the low bits.
    localparam int CW = 32;
    localparam logic [1:0] OP_ENC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_CHAN, S_DEC, S_DONE} state_t;

    state_t               state;
    logic [1:0]           ctrl_r, width_r, op_s, width_s;
    logic [AMBA_WORD-1:0] data_in_r, noise_r, op_count, err_count, rd_mux;
    logic                 illegal_r, reject_r;
    logic [CW-1:0]        work, noise_s, enc_word;
    logic [CW+1:0]        dec_res;
    logic [2:0]           reg_addr;
    logic                 wr_en, ctrl_wr, status_rd, accept, op_ok, width_ok, start, fin;
    logic [1:0]           fin_err;
    logic                 addr_unused;

    function automatic int width_of(input logic [1:0] ws);
        int w;
        case (ws)
            2'b00:   w = 8;
            2'b01:   w = 16;
            default: w = 32;
        endcase
        return w;
    endfunction

    // Data bits fill non-power-of-two positions from 3 upward; check bit 2^j covers positions with bit j set.
    function automatic logic [CW-1:0] encode(input logic [CW-1:0] d, input logic [1:0] ws);
        logic [CW-1:0] cw;
        logic          p;
        int            w;
        int            k;
        w  = width_of(ws);
        cw = '0;
        k  = 0;
        for (int n = 3; n < CW; n++) begin
            if (n < w && (n & (n - 1)) != 0) begin
                cw[n] = d[k];
                k = k + 1;
            end
        end
        for (int j = 0; j < 5; j++) begin
            p = 1'b0;
            for (int n = 3; n < CW; n++) begin
                if (n < w && ((n >> j) & 1) != 0) p = p ^ cw[n];
            end
            if ((1 << j) < w) cw[1 << j] = p;
        end
        p = 1'b0;
        for (int n = 1; n < CW; n++) begin
            if (n < w) p = p ^ cw[n];
        end
        cw[0] = p;
        return cw;
    endfunction

    // Returns {error class, extracted data}; a syndrome of 0 with odd parity means bit 0 itself flipped.
    function automatic logic [CW+1:0] decode(input logic [CW-1:0] cw_in, input logic [1:0] ws);
        logic [CW-1:0] cw;
        logic [CW-1:0] d;
        logic [4:0]    s;
        logic          p;
        logic [1:0]    e;
        int            w;
        int            k;
        w  = width_of(ws);
        cw = cw_in;
        s  = '0;
        p  = 1'b0;
        d  = '0;
        k  = 0;
        for (int n = 0; n < CW; n++) begin
            if (n < w && cw[n]) begin
                p = ~p;
                s = s ^ 5'(n);
            end
        end
        if (p) begin
            cw[s] = ~cw[s];
            e = 2'b01;
        end else if (s != 5'd0) begin
            e = 2'b10;
        end else begin
            e = 2'b00;
        end
        for (int n = 3; n < CW; n++) begin
            if (n < w && (n & (n - 1)) != 0) begin
                d[k] = cw[n];
                k = k + 1;
            end
        end
        return {e, d};
    endfunction

    assign reg_addr    = PADDR[4:2];
    assign addr_unused = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign ctrl_wr     = wr_en && (reg_addr == 3'b000);
    assign status_rd   = PSEL & PENABLE & ~PWRITE & (reg_addr == 3'b100);
    assign accept      = ctrl_wr && (state == S_IDLE);
    assign op_ok       = PWDATA[1:0] != OP_ILL;
    assign width_ok    = (width_r != 2'b11) && (width_of(width_r) <= DATA_WIDTH);
    assign start       = accept && op_ok && width_ok;
    assign enc_word    = encode(work, width_s);
    assign dec_res     = decode(work, width_s);
    assign fin         = ((state == S_ENC) && (op_s == OP_ENC)) || (state == S_DEC);
    assign fin_err     = (state == S_DEC) ? dec_res[CW+1:CW] : 2'b00;

    // Register file writes plus the sticky reject/illegal flags; a new event outranks a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_r    <= '0;
            width_r   <= '0;
            data_in_r <= '0;
            noise_r   <= '0;
            illegal_r <= 1'b0;
            reject_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_addr)
                    3'b000:  ctrl_r    <= PWDATA[1:0];
                    3'b001:  data_in_r <= PWDATA;
                    3'b010:  width_r   <= PWDATA[1:0];
                    3'b011:  noise_r   <= PWDATA;
                    default: ;
                endcase
            end
            if (status_rd) begin
                illegal_r <= 1'b0;
                reject_r  <= 1'b0;
            end
            if (ctrl_wr && state != S_IDLE) reject_r <= 1'b1;
            if (accept && !(op_ok && width_ok)) illegal_r <= 1'b1;
        end
    end

    // Operation FSM: snapshots operands on accept and registers the result on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            op_s           <= '0;
            width_s        <= '0;
            work           <= '0;
            noise_s        <= '0;
            data_out       <= '0;
            num_of_errors  <= '0;
            operation_done <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= (PWDATA[1:0] == OP_DEC) ? S_DEC : S_ENC;
                        op_s    <= PWDATA[1:0];
                        width_s <= width_r;
                        work    <= CW'(data_in_r);
                        noise_s <= CW'(noise_r);
                    end
                end
                S_ENC: begin
                    work <= enc_word;
                    if (op_s == OP_ENC) begin
                        data_out       <= enc_word[DATA_WIDTH-1:0];
                        num_of_errors  <= 2'b00;
                        operation_done <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        state <= S_CHAN;
                    end
                end
                S_CHAN: begin
                    work  <= work ^ noise_s;
                    state <= S_DEC;
                end
                S_DEC: begin
                    data_out       <= dec_res[DATA_WIDTH-1:0];
                    num_of_errors  <= dec_res[CW+1:CW];
                    operation_done <= 1'b1;
                    state          <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Event counters; a register clear wins over an increment on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else begin
            if (wr_en && reg_addr == 3'b101) op_count <= '0;
            else if (fin) op_count <= op_count + AMBA_WORD'(1);
            if (wr_en && reg_addr == 3'b110) err_count <= '0;
            else if (fin && fin_err == 2'b10 && err_count != '1) err_count <= err_count + AMBA_WORD'(1);
        end
    end

    // Read-data selection for the register map.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            3'b000:  rd_mux = AMBA_WORD'(ctrl_r);
            3'b001:  rd_mux = data_in_r;
            3'b010:  rd_mux = AMBA_WORD'(width_r);
            3'b011:  rd_mux = noise_r;
            3'b100:  rd_mux = AMBA_WORD'({state != S_IDLE, illegal_r, reject_r, num_of_errors});
            3'b101:  rd_mux = op_count;
            3'b110:  rd_mux = err_count;
            default: rd_mux = '0;
        endcase
    end

    // Read data is captured on both setup and access edges of a read and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) PRDATA <= '0;
        else if (PSEL && !PWRITE) PRDATA <= rd_mux;
    end
endmodule

// File: tb/tb_ecc_secded_engine.sv
// tb/tb_ecc_secded_engine.sv - directed self-checking bench for ecc_secded_engine
module tb_ecc_secded_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic        psel_a = 1'b0;
    logic        psel_b = 1'b0;
    logic [31:0] prdata_a, data_out_a;
    logic        done_a;
    logic [1:0]  noe_a;
    logic [7:0]  prdata_b;
    logic [15:0] data_out_b;
    logic        done_b;
    logic [1:0]  noe_b;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt_a = 0;
    int          done_cnt_b = 0;
    logic [31:0] rd;
    int          d0;

    always #5 clk = ~clk;

    ecc_secded_engine u_dut_a (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PENABLE(penable),
        .PSEL(psel_a), .PWRITE(pwrite), .PRDATA(prdata_a), .data_out(data_out_a),
        .operation_done(done_a), .num_of_errors(noe_a)
    );

    ecc_secded_engine #(.DATA_WIDTH(16), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(8)) u_dut_b (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata[7:0]), .PENABLE(penable),
        .PSEL(psel_b), .PWRITE(pwrite), .PRDATA(prdata_b), .data_out(data_out_b),
        .operation_done(done_b), .num_of_errors(noe_b)
    );

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input int inst, input logic [2:0] addr, input logic [31:0] data);
        paddr   = {15'b0, addr, 2'b00};
        pwdata  = data;
        pwrite  = 1'b1;
        psel_a  = (inst == 0);
        psel_b  = (inst == 1);
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input int inst, input logic [2:0] addr, output logic [31:0] data);
        paddr   = {15'b0, addr, 2'b00};
        pwrite  = 1'b0;
        psel_a  = (inst == 0);
        psel_b  = (inst == 1);
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        data    = (inst == 0) ? prdata_a : {24'b0, prdata_b};
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int max, output int lat);
        lat = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            lat++;
            if ((inst == 0) ? done_a : done_b) break;
        end
    endtask

    task automatic run_op(input int inst, input logic [1:0] op, input int exp_lat, input string tag);
        int lat;
        apb_write(inst, 3'd0, {30'b0, op});
        wait_done(inst, 8, lat);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out_a, 32'h0);
        check("rst_noe", {30'b0, noe_a}, 32'h0);
        check("rst_done", {31'b0, done_a}, 32'h0);
        check("rst_prdata", prdata_a, 32'h0);
        rst = 1'b1;
        apb_read(0, 3'd4, rd);
        check("rst_status", rd, 32'h0);

        // Width 8 encode of 0xB
        apb_write(0, 3'd2, 32'h0);
        apb_write(0, 3'd1, 32'hB);
        run_op(0, 2'b00, 1, "enc8");
        check("enc8_data", data_out_a, 32'hAA);
        check("enc8_noe", {30'b0, noe_a}, 32'h0);
        @(posedge clk); #1;
        check("enc8_done_width", {31'b0, done_a}, 32'h0);
        apb_read(0, 3'd5, rd);
        check("enc8_opcount", rd, 32'h1);

        // Full channel with single-bit noise, including noise on bit 0
        apb_write(0, 3'd3, 32'h04);
        run_op(0, 2'b10, 3, "chan_n4");
        check("chan_n4_data", data_out_a, 32'hB);
        check("chan_n4_noe", {30'b0, noe_a}, 32'h1);
        apb_write(0, 3'd3, 32'h01);
        run_op(0, 2'b10, 3, "chan_n1");
        check("chan_n1_data", data_out_a, 32'hB);
        check("chan_n1_noe", {30'b0, noe_a}, 32'h1);

        // Double error decode, then ERR_COUNT read and clear
        apb_write(0, 3'd1, 32'hAC);
        run_op(0, 2'b01, 1, "dec_dbl");
        check("dec_dbl_data", data_out_a, 32'hB);
        check("dec_dbl_noe", {30'b0, noe_a}, 32'h2);
        apb_read(0, 3'd6, rd);
        check("errcount_1", rd, 32'h1);
        apb_write(0, 3'd6, 32'h0);
        apb_read(0, 3'd6, rd);
        check("errcount_clr", rd, 32'h0);
        apb_read(0, 3'd5, rd);
        check("opcount_4", rd, 32'h4);

        // Mid-run register writes: operands are snapshotted, CTRL write on the DONE edge is rejected
        apb_write(0, 3'd1, 32'hB);
        apb_write(0, 3'd3, 32'h04);
        d0 = done_cnt_a;
        apb_write(0, 3'd0, 32'h2);
        apb_write(0, 3'd1, 32'h5);
        apb_write(0, 3'd0, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("mid_done_cnt", done_cnt_a, d0 + 1);
        check("mid_data", data_out_a, 32'hB);
        check("mid_noe", {30'b0, noe_a}, 32'h1);
        apb_read(0, 3'd0, rd);
        check("mid_ctrl_rb", rd, 32'h1);
        apb_read(0, 3'd4, rd);
        check("mid_status_rej", rd, 32'h5);
        apb_read(0, 3'd4, rd);
        check("mid_status_clr", rd, 32'h1);

        // Illegal width code
        apb_write(0, 3'd2, 32'h3);
        d0 = done_cnt_a;
        apb_write(0, 3'd0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("ill_w_nodone", done_cnt_a, d0);
        apb_read(0, 3'd4, rd);
        check("ill_w_status", rd, 32'h9);
        apb_read(0, 3'd4, rd);
        check("ill_w_status_clr", rd, 32'h1);

        // Width 16 layout
        apb_write(0, 3'd2, 32'h1);
        apb_write(0, 3'd1, 32'hFFFF);
        run_op(0, 2'b00, 1, "enc16_ones");
        check("enc16_ones_data", data_out_a, 32'hFFFF);
        check("enc16_ones_noe", {30'b0, noe_a}, 32'h0);
        apb_write(0, 3'd1, 32'h400);
        run_op(0, 2'b00, 1, "enc16_d10");
        check("enc16_d10_data", data_out_a, 32'h8117);
        apb_write(0, 3'd1, 32'h8114);
        run_op(0, 2'b01, 1, "dec16_dbl");
        check("dec16_dbl_data", data_out_a, 32'h400);
        check("dec16_dbl_noe", {30'b0, noe_a}, 32'h2);

        // Width 32 layout
        apb_write(0, 3'd2, 32'h2);
        apb_write(0, 3'd1, 32'hFFFF_FFFF);
        run_op(0, 2'b00, 1, "enc32_ones");
        check("enc32_ones_data", data_out_a, 32'hFFFF_FFFF);
        check("enc32_ones_noe", {30'b0, noe_a}, 32'h0);
        apb_write(0, 3'd1, 32'h0200_0000);
        run_op(0, 2'b00, 1, "enc32_d25");
        check("enc32_d25_data", data_out_a, 32'h8001_0116);
        apb_write(0, 3'd1, 32'h8011_0116);
        run_op(0, 2'b01, 1, "dec32_sgl");
        check("dec32_sgl_data", data_out_a, 32'h0200_0000);
        check("dec32_sgl_noe", {30'b0, noe_a}, 32'h1);

        // Reset while in CHAN aborts with no done pulse
        apb_write(0, 3'd2, 32'h0);
        apb_write(0, 3'd1, 32'hB);
        apb_write(0, 3'd3, 32'h04);
        d0 = done_cnt_a;
        apb_write(0, 3'd0, 32'h2);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstchan_data", data_out_a, 32'h0);
        check("rstchan_noe", {30'b0, noe_a}, 32'h0);
        check("rstchan_done", {31'b0, done_a}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstchan_nodone", done_cnt_a, d0);
        apb_read(0, 3'd5, rd);
        check("rstchan_opcount", rd, 32'h0);
        apb_write(0, 3'd1, 32'hB);
        run_op(0, 2'b00, 1, "post_rst_enc");
        check("post_rst_data", data_out_a, 32'hAA);

        // Narrow instance: width 32 exceeds DATA_WIDTH=16
        apb_write(1, 3'd2, 32'h2);
        d0 = done_cnt_b;
        apb_write(1, 3'd0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("b_ill_nodone", done_cnt_b, d0);
        apb_read(1, 3'd4, rd);
        check("b_ill_status", rd, 32'h8);

        // Narrow instance: ERR_COUNT saturation and OP_COUNT wrap at 8 bits
        apb_write(1, 3'd2, 32'h0);
        apb_write(1, 3'd1, 32'hAC);
        for (int i = 0; i < 256; i++) begin
            run_op(1, 2'b01, 1, "b_dec");
            if (i == 253) begin
                apb_read(1, 3'd6, rd);
                check("b_err_254", rd, 32'hFE);
            end
        end
        check("b_dec_data", {16'b0, data_out_b}, 32'hB);
        check("b_dec_noe", {30'b0, noe_b}, 32'h2);
        apb_read(1, 3'd6, rd);
        check("b_err_sat", rd, 32'hFF);
        apb_read(1, 3'd5, rd);
        check("b_op_wrap", rd, 32'h0);
        apb_write(1, 3'd6, 32'h0);
        apb_read(1, 3'd6, rd);
        check("b_err_clr", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
